// File: rtl/wb_burst_master_pkg.sv
// Local definitions for wb_burst_master: FSM state encodings, counter widths
// and the latched command control payload.
package wb_burst_master_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_BEAT   = 2'd1;
   localparam logic [1:0] ST_GAP    = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   localparam int unsigned LEN_W   = 8;
   localparam int unsigned BEATS_W = 9;

   // Control part of an accepted command (address and length held separately)
   typedef struct packed {
      logic       we;
      logic [2:0] burst;
   } cmd_ctl_t;

endpackage

// File: rtl/wb_common_pkg.sv
// Shared Wishbone definitions: cycle type identifiers (CTI), burst type
// extensions (BTE) and the burst-type codes used on the command interface.
package wb_common_pkg;

   // Cycle type identifier codes
   localparam logic [2:0] CTI_CLASSIC  = 3'b000;
   localparam logic [2:0] CTI_INCR     = 3'b010;
   localparam logic [2:0] CTI_EOB      = 3'b111;

   // Burst type extension codes
   localparam logic [1:0] BTE_LINEAR   = 2'b00;
   localparam logic [1:0] BTE_WRAP4    = 2'b01;
   localparam logic [1:0] BTE_WRAP8    = 2'b10;
   localparam logic [1:0] BTE_WRAP16   = 2'b11;

   // Command burst-type codes
   localparam logic [2:0] BURST_CLASSIC = 3'd0;
   localparam logic [2:0] BURST_LINEAR  = 3'd1;
   localparam logic [2:0] BURST_WRAP4   = 3'd2;
   localparam logic [2:0] BURST_WRAP8   = 3'd3;
   localparam logic [2:0] BURST_WRAP16  = 3'd4;

   // Map a command burst type onto the bus BTE field; unknown codes run linear
   function automatic logic [1:0] bte_of(input logic [2:0] burst);
      logic [1:0] bte;
      case (burst)
         BURST_LINEAR: bte = BTE_LINEAR;
         BURST_WRAP4:  bte = BTE_WRAP4;
         BURST_WRAP8:  bte = BTE_WRAP8;
         BURST_WRAP16: bte = BTE_WRAP16;
         default:      bte = BTE_LINEAR;
      endcase
      return bte;
   endfunction

endpackage

// File: rtl/wb_next_adr.sv
// Next beat address for a Wishbone burst.
// Ports:
//   adr_i      current beat address
//   burst_i    command burst type (classic/linear/wrap4/wrap8/wrap16)
//   next_adr_o address of the following beat (purely combinational)
// Wrap bursts keep the bits above the aligned N-beat block unchanged;
// classic and linear simply add one data word with natural wrap-around.
module wb_next_adr
   import wb_common_pkg::*;
#(
   parameter int unsigned aw = 32,
   parameter int unsigned dw = 32
) (
   input  logic [aw-1:0] adr_i,
   input  logic [2:0]    burst_i,
   output logic [aw-1:0] next_adr_o
);

   localparam int unsigned   STEP   = dw / 8;
   localparam logic [aw-1:0] STEP_A = aw'(STEP);
   localparam logic [aw-1:0] MASK4  = aw'(4 * STEP - 1);
   localparam logic [aw-1:0] MASK8  = aw'(8 * STEP - 1);
   localparam logic [aw-1:0] MASK16 = aw'(16 * STEP - 1);

   logic [aw-1:0] mask;
   logic [aw-1:0] incr;

   // An all-ones mask degenerates into a plain increment
   always_comb begin
      mask = '1;
      case (burst_i)
         BURST_WRAP4:  mask = MASK4;
         BURST_WRAP8:  mask = MASK8;
         BURST_WRAP16: mask = MASK16;
         default:      mask = '1;
      endcase
      incr       = adr_i + STEP_A;
      next_adr_o = (adr_i & ~mask) | (incr & mask);
   end

endmodule

// File: rtl/wb_burst_master.sv
// Command-driven Wishbone B4 burst master.
// Ports:
//   wb_clk, wb_rst                 clock, synchronous active-high reset
//   cmd_*                          command handshake (we, adr, len = beats-1, burst type)
//   wdat_valid/wdat_ready/wdat/wsel write-data handshake into a one-entry register
//   rdat_valid/rdat                registered read data, one pulse per read ack
//   done/status_*                  completion pulse and sticky status until next command
//   wb_*                           Wishbone master interface
// Classic commands insert a one-cycle GAP (cyc high, stb low) after each ack;
// burst commands keep stb high and tag the last beat with end-of-burst.
module wb_burst_master
   import wb_common_pkg::*;
   import wb_burst_master_pkg::*;
#(
   parameter int unsigned dw      = 32,
   parameter int unsigned aw      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            wb_clk,
   input  logic            wb_rst,
   // command
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [aw-1:0]   cmd_adr,
   input  logic [7:0]      cmd_len,
   input  logic [2:0]      cmd_burst,
   // write data
   input  logic            wdat_valid,
   output logic            wdat_ready,
   input  logic [dw-1:0]   wdat,
   input  logic [dw/8-1:0] wsel,
   // read data
   output logic            rdat_valid,
   output logic [dw-1:0]   rdat,
   // status
   output logic            done,
   output logic            status_err,
   output logic            status_timeout,
   output logic [8:0]      status_beats,
   // wishbone master
   output logic [aw-1:0]   wb_adr_o,
   output logic [dw-1:0]   wb_dat_o,
   output logic [dw/8-1:0] wb_sel_o,
   output logic            wb_we_o,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic [2:0]      wb_cti_o,
   output logic [1:0]      wb_bte_o,
   input  logic [dw-1:0]   wb_dat_i,
   input  logic            wb_ack_i,
   input  logic            wb_err_i,
   input  logic            wb_rty_i
);

   localparam int unsigned SW       = dw / 8;
   localparam int unsigned TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   logic [1:0]         state_q, state_d;
   cmd_ctl_t           ctl_q, ctl_d;
   logic [aw-1:0]      adr_q, adr_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic               wfull_q, wfull_d;
   logic [dw-1:0]      wdat_q, wdat_d;
   logic [SW-1:0]      wsel_q, wsel_d;
   logic [BEATS_W-1:0] beats_q, beats_d;
   logic [TW-1:0]      tmo_q, tmo_d;
   logic               err_q, err_d;
   logic               tmo_flag_q, tmo_flag_d;
   logic               rvalid_q, rvalid_d;
   logic [dw-1:0]      rdat_q, rdat_d;

   logic               cyc;
   logic               stb;
   logic               bad;
   logic               hit_err;
   logic               hit_ack;
   logic               last;
   logic               classic;
   logic               wr_hs;
   logic [aw-1:0]      next_adr;

   wb_next_adr #(
      .aw (aw),
      .dw (dw)
   ) u_next_adr (
      .adr_i      (adr_q),
      .burst_i    (ctl_q.burst),
      .next_adr_o (next_adr)
   );

   // Bus-phase decode; a write beat only strobes once its data is held
   always_comb begin
      cyc     = (state_q == ST_BEAT) || (state_q == ST_GAP);
      stb     = (state_q == ST_BEAT) && (!ctl_q.we || wfull_q);
      bad     = wb_err_i || wb_rty_i;
      hit_err = stb && bad;
      hit_ack = stb && wb_ack_i && !bad;
      last    = (rem_q == '0);
      classic = (ctl_q.burst == BURST_CLASSIC);
      // Refill in the same cycle the held word is acked, unless nothing is left
      wdat_ready = cyc && ctl_q.we && (!wfull_q || (hit_ack && !last));
      wr_hs      = wdat_valid && wdat_ready;
   end

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      ctl_d      = ctl_q;
      adr_d      = adr_q;
      rem_d      = rem_q;
      wfull_d    = wfull_q;
      wdat_d     = wdat_q;
      wsel_d     = wsel_q;
      beats_d    = beats_q;
      tmo_d      = tmo_q;
      err_d      = err_q;
      tmo_flag_d = tmo_flag_q;
      rvalid_d   = 1'b0;
      rdat_d     = rdat_q;

      if (hit_ack) begin
         wfull_d = 1'b0;
      end
      if (wr_hs) begin
         wfull_d = 1'b1;
         wdat_d  = wdat;
         wsel_d  = wsel;
      end

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               ctl_d.we    = cmd_we;
               ctl_d.burst = cmd_burst;
               adr_d       = cmd_adr;
               rem_d       = cmd_len;
               beats_d     = '0;
               tmo_d       = '0;
               err_d       = 1'b0;
               tmo_flag_d  = 1'b0;
               wfull_d     = 1'b0;
               state_d     = ST_BEAT;
            end
         end
         ST_BEAT: begin
            if (hit_err) begin
               err_d   = 1'b1;
               wfull_d = 1'b0;
               state_d = ST_FINISH;
            end else if (hit_ack) begin
               beats_d  = beats_q + BEATS_W'(1);
               adr_d    = next_adr;
               tmo_d    = '0;
               rvalid_d = !ctl_q.we;
               if (!ctl_q.we) begin
                  rdat_d = wb_dat_i;
               end
               if (last) begin
                  state_d = ST_FINISH;
               end else begin
                  rem_d   = rem_q - LEN_W'(1);
                  state_d = classic ? ST_GAP : ST_BEAT;
               end
            end else if (stb) begin
               // Unanswered strobe: abort once the per-beat budget is spent
               if (tmo_q == TMO_LAST) begin
                  err_d      = 1'b1;
                  tmo_flag_d = 1'b1;
                  wfull_d    = 1'b0;
                  state_d    = ST_FINISH;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end
         end
         ST_GAP: begin
            state_d = ST_BEAT;
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q    <= ST_IDLE;
         ctl_q      <= '0;
         adr_q      <= '0;
         rem_q      <= '0;
         wfull_q    <= 1'b0;
         wdat_q     <= '0;
         wsel_q     <= '0;
         beats_q    <= '0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
         tmo_flag_q <= 1'b0;
         rvalid_q   <= 1'b0;
         rdat_q     <= '0;
      end else begin
         state_q    <= state_d;
         ctl_q      <= ctl_d;
         adr_q      <= adr_d;
         rem_q      <= rem_d;
         wfull_q    <= wfull_d;
         wdat_q     <= wdat_d;
         wsel_q     <= wsel_d;
         beats_q    <= beats_d;
         tmo_q      <= tmo_d;
         err_q      <= err_d;
         tmo_flag_q <= tmo_flag_d;
         rvalid_q   <= rvalid_d;
         rdat_q     <= rdat_d;
      end
   end

   // Output decode from registered state only
   always_comb begin
      cmd_ready      = (state_q == ST_IDLE);
      done           = (state_q == ST_FINISH);
      status_err     = err_q;
      status_timeout = tmo_flag_q;
      status_beats   = beats_q;
      rdat_valid     = rvalid_q;
      rdat           = rdat_q;
      wb_cyc_o       = cyc;
      wb_stb_o       = stb;
      wb_we_o        = cyc && ctl_q.we;
      wb_adr_o       = adr_q;
      wb_dat_o       = wdat_q;
      wb_sel_o       = '0;
      wb_cti_o       = CTI_CLASSIC;
      wb_bte_o       = BTE_LINEAR;
      if (cyc) begin
         wb_sel_o = ctl_q.we ? wsel_q : '1;
         wb_bte_o = classic ? BTE_LINEAR : bte_of(ctl_q.burst);
         if (!classic) begin
            wb_cti_o = last ? CTI_EOB : CTI_INCR;
         end
      end
   end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed self-checking bench for wb_burst_master.
module tb_wb_burst_master;

   logic        wb_clk = 1'b0;
   logic        wb_rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr;
   logic [7:0]  cmd_len;
   logic [2:0]  cmd_burst;
   logic        wdat_valid, wdat_ready;
   logic [31:0] wdat;
   logic [3:0]  wsel;
   logic        rdat_valid;
   logic [31:0] rdat;
   logic        done, status_err, status_timeout;
   logic [8:0]  status_beats;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;
   logic        wb_ack_i, wb_err_i, wb_rty_i;

   int total = 0;
   int bad   = 0;

   always #5 wb_clk = ~wb_clk;

   wb_burst_master #(.dw(32), .aw(32), .TIMEOUT(10)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
      .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat), .wsel(wsel),
      .rdat_valid(rdat_valid), .rdat(rdat),
      .done(done), .status_err(status_err), .status_timeout(status_timeout),
      .status_beats(status_beats),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
   );

   // Slave model: immediate responses, read data derived from address
   logic ack_en = 1'b1, err_en = 1'b0, rty_en = 1'b0;
   int   sl_cnt = 0;
   int   err_at = 0;
   assign wb_ack_i = wb_cyc_o & wb_stb_o & ack_en;
   assign wb_err_i = wb_cyc_o & wb_stb_o & err_en & (sl_cnt == err_at);
   assign wb_rty_i = wb_cyc_o & wb_stb_o & rty_en;
   assign wb_dat_i = 32'hA500_0000 ^ wb_adr_o;

   always @(posedge wb_clk)
      if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i) sl_cnt <= sl_cnt + 1;

   // Bus monitor sampled mid-cycle
   logic [31:0] log_adr [0:255];
   logic [31:0] log_dat [0:255];
   logic [2:0]  log_cti [0:255];
   logic [1:0]  log_bte [0:255];
   logic [3:0]  log_sel [0:255];
   logic [31:0] log_rd  [0:255];
   int ack_n = 0, rd_n = 0, done_n = 0, stb_n = 0, gap_n = 0, gap_cti_bad = 0;
   int cyc_after_err = -1;
   logic err_pend = 1'b0;

   always @(negedge wb_clk) begin
      if (wb_cyc_o && wb_stb_o) stb_n <= stb_n + 1;
      if (wb_cyc_o && !wb_stb_o) begin
         gap_n <= gap_n + 1;
         if (wb_cti_o != 3'b010) gap_cti_bad <= gap_cti_bad + 1;
      end
      if (err_pend) cyc_after_err <= int'(wb_cyc_o);
      err_pend <= wb_cyc_o && wb_stb_o && (wb_err_i || wb_rty_i);
      if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i) begin
         log_adr[ack_n[7:0]] <= wb_adr_o;
         log_dat[ack_n[7:0]] <= wb_dat_o;
         log_cti[ack_n[7:0]] <= wb_cti_o;
         log_bte[ack_n[7:0]] <= wb_bte_o;
         log_sel[ack_n[7:0]] <= wb_sel_o;
         ack_n <= ack_n + 1;
      end
      if (rdat_valid) begin
         log_rd[rd_n[7:0]] <= rdat;
         rd_n <= rd_n + 1;
      end
      if (done) done_n <= done_n + 1;
   end

   logic [31:0] wq [0:15];

   task automatic tick();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [31:0] adr, input logic [7:0] len,
                        input logic [2:0] burst);
      cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_burst = burst;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int base, input string name);
      for (int i = 0; i < 200 && done_n == base; i++) tick();
      total++;
      if (done_n !== base + 1) begin
         bad++;
         $display("FAIL %s_done: pulses=%0d want=1", name, done_n - base);
      end
   endtask

   // Feed write words from wq; optionally hold valid low after stall_after words
   task automatic run_write(input logic [31:0] adr, input logic [7:0] len, input logic [2:0] burst,
                            input int n, input int stall_after, input int stall_len);
      int idx = 0, stall = 0;
      int base = done_n;
      logic hs;
      wsel = 4'hF; wdat = wq[0]; wdat_valid = 1'b1;
      issue(1'b1, adr, len, burst);
      for (int c = 0; c < 200 && done_n == base; c++) begin
         @(negedge wb_clk);
         hs = wdat_valid & wdat_ready;
         @(posedge wb_clk);
         #1;
         if (hs) begin
            idx++;
            if (idx == stall_after) stall = stall_len;
         end
         if (stall > 0) begin
            wdat_valid = 1'b0;
            stall--;
         end else if (idx < n) begin
            wdat_valid = 1'b1;
            wdat = wq[idx[3:0]];
         end else begin
            wdat_valid = 1'b0;
         end
      end
      wdat_valid = 1'b0;
   endtask

   task automatic test_reset();
      wb_rst = 1'b1;
      repeat (3) tick();
      total++;
      if ({cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, done, status_err, status_timeout,
           wdat_ready, rdat_valid} !== 9'b1_0000_0000) begin
         bad++;
         $display("FAIL reset_ctl: got %b want 100000000", {cmd_ready, wb_cyc_o, wb_stb_o,
                  wb_we_o, done, status_err, status_timeout, wdat_ready, rdat_valid});
      end
      total++;
      if (status_beats !== 9'd0) begin
         bad++; $display("FAIL reset_beats: got %0d want 0", status_beats);
      end
      total++;
      if ({wb_adr_o, wb_cti_o, wb_bte_o, wb_sel_o, rdat} !== 73'd0) begin
         bad++; $display("FAIL reset_bus: adr=%h cti=%b bte=%b want all zero", wb_adr_o, wb_cti_o, wb_bte_o);
      end
      wb_rst = 1'b0;
      tick();
   endtask

   task automatic test_classic_write();
      int b = ack_n, s = stb_n, d = done_n;
      wq[0] = 32'hDEAD_BEEF;
      run_write(32'h100, 8'd0, 3'd0, 1, -1, 0);
      wait_done(d, "classic_wr");
      total++;
      if (ack_n - b !== 1 || stb_n - s !== 1) begin
         bad++; $display("FAIL classic_wr_count: acks=%0d stbs=%0d want 1/1", ack_n - b, stb_n - s);
      end
      total++;
      if ({log_adr[8'(b)], log_dat[8'(b)], log_cti[8'(b)], log_sel[8'(b)]} !== {32'h100, 32'hDEAD_BEEF, 3'b000, 4'hF}) begin
         bad++;
         $display("FAIL classic_wr_beat: adr=%h dat=%h cti=%b sel=%h want 100 deadbeef 000 f",
                  log_adr[8'(b)], log_dat[8'(b)], log_cti[8'(b)], log_sel[8'(b)]);
      end
      total++;
      if (status_beats !== 9'd1 || status_err !== 1'b0) begin
         bad++; $display("FAIL classic_wr_status: beats=%0d err=%b want 1 0", status_beats, status_err);
      end
   endtask

   task automatic test_classic_gap_read();
      int b = ack_n, g = gap_n, r = rd_n, d = done_n;
      issue(1'b0, 32'h200, 8'd1, 3'd0);
      wait_done(d, "classic_rd");
      total++;
      if (ack_n - b !== 2 || gap_n - g !== 1 || rd_n - r !== 2) begin
         bad++; $display("FAIL classic_rd_count: acks=%0d gaps=%0d rd=%0d want 2 1 2", ack_n - b, gap_n - g, rd_n - r);
      end
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({log_adr[8'(b + i)], log_cti[8'(b + i)], log_rd[8'(r + i)]} !==
             {32'h200 + 32'(4 * i), 3'b000, 32'hA500_0200 + 32'(4 * i)}) begin
            bad++;
            $display("FAIL classic_rd_beat%0d: adr=%h cti=%b rdat=%h want %h 000 %h", i,
                     log_adr[8'(b + i)], log_cti[8'(b + i)], log_rd[8'(r + i)],
                     32'h200 + 32'(4 * i), 32'hA500_0200 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_wrap4_read();
      logic [31:0] ea [0:3];
      logic [2:0]  ec [0:3];
      int b = ack_n, g = gap_n, r = rd_n, d = done_n;
      ea[0] = 32'h1C; ea[1] = 32'h10; ea[2] = 32'h14; ea[3] = 32'h18;
      ec[0] = 3'b010; ec[1] = 3'b010; ec[2] = 3'b010; ec[3] = 3'b111;
      issue(1'b0, 32'h1C, 8'd3, 3'd2);
      wait_done(d, "wrap4");
      total++;
      if (ack_n - b !== 4 || rd_n - r !== 4 || gap_n - g !== 0 || status_beats !== 9'd4) begin
         bad++; $display("FAIL wrap4_count: acks=%0d rd=%0d gaps=%0d beats=%0d want 4 4 0 4",
                         ack_n - b, rd_n - r, gap_n - g, status_beats);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({log_adr[8'(b + i)], log_cti[8'(b + i)], log_bte[8'(b + i)], log_rd[8'(r + i)]} !==
             {ea[i], ec[i], 2'b01, 32'hA500_0000 ^ ea[i]}) begin
            bad++;
            $display("FAIL wrap4_beat%0d: adr=%h cti=%b bte=%b rdat=%h want %h %b 01 %h", i,
                     log_adr[8'(b + i)], log_cti[8'(b + i)], log_bte[8'(b + i)], log_rd[8'(r + i)],
                     ea[i], ec[i], 32'hA500_0000 ^ ea[i]);
         end
      end
   endtask

   task automatic test_linear_stall_write();
      int b = ack_n, g = gap_n, gc = gap_cti_bad, d = done_n;
      for (int i = 0; i < 8; i++) wq[i] = 32'h1111_0000 + 32'(i);
      run_write(32'h300, 8'd7, 3'd1, 8, 3, 3);
      wait_done(d, "linear");
      total++;
      // one startup cycle before the first word, then three stalled cycles
      if (ack_n - b !== 8 || gap_n - g !== 4 || gap_cti_bad - gc !== 0 || status_beats !== 9'd8) begin
         bad++; $display("FAIL linear_count: acks=%0d stb_low=%0d cti_bad=%0d beats=%0d want 8 4 0 8",
                         ack_n - b, gap_n - g, gap_cti_bad - gc, status_beats);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if ({log_adr[8'(b + i)], log_dat[8'(b + i)], log_cti[8'(b + i)], log_bte[8'(b + i)]} !==
             {32'h300 + 32'(4 * i), 32'h1111_0000 + 32'(i), (i == 7) ? 3'b111 : 3'b010, 2'b00}) begin
            bad++;
            $display("FAIL linear_beat%0d: adr=%h dat=%h cti=%b bte=%b", i,
                     log_adr[8'(b + i)], log_dat[8'(b + i)], log_cti[8'(b + i)], log_bte[8'(b + i)]);
         end
      end
   endtask

   task automatic test_single_burst();
      int b = ack_n, d = done_n;
      issue(1'b0, 32'h40, 8'd0, 3'd3);
      wait_done(d, "single");
      total++;
      if (ack_n - b !== 1 || log_cti[8'(b)] !== 3'b111 || log_bte[8'(b)] !== 2'b10 || status_beats !== 9'd1) begin
         bad++; $display("FAIL single_burst: acks=%0d cti=%b bte=%b beats=%0d want 1 111 10 1",
                         ack_n - b, log_cti[8'(b)], log_bte[8'(b)], status_beats);
      end
   endtask

   task automatic test_err_read();
      int b = ack_n, r = rd_n, d = done_n;
      err_at = sl_cnt + 1;
      err_en = 1'b1;
      issue(1'b0, 32'h400, 8'd3, 3'd1);
      wait_done(d, "err");
      err_en = 1'b0;
      total++;
      if ({status_err, status_timeout, status_beats} !== {1'b1, 1'b0, 9'd1}) begin
         bad++; $display("FAIL err_status: err=%b tmo=%b beats=%0d want 1 0 1", status_err, status_timeout, status_beats);
      end
      total++;
      if (cyc_after_err !== 0 || ack_n - b !== 1 || rd_n - r !== 1) begin
         bad++; $display("FAIL err_bus: cyc_after=%0d acks=%0d rd=%0d want 0 1 1", cyc_after_err, ack_n - b, rd_n - r);
      end
   endtask

   task automatic test_rty();
      int d = done_n;
      rty_en = 1'b1;
      issue(1'b0, 32'h500, 8'd0, 3'd0);
      total++;
      if ({status_err, cmd_ready, wb_cyc_o} !== 3'b001) begin
         bad++; $display("FAIL rty_clear: err=%b ready=%b cyc=%b want 0 0 1", status_err, cmd_ready, wb_cyc_o);
      end
      wait_done(d, "rty");
      rty_en = 1'b0;
      total++;
      if ({status_err, status_timeout, status_beats, cyc_after_err} !== {1'b1, 1'b0, 9'd0, 32'd0}) begin
         bad++; $display("FAIL rty_status: err=%b tmo=%b beats=%0d cyc_after=%0d want 1 0 0 0",
                         status_err, status_timeout, status_beats, cyc_after_err);
      end
   endtask

   task automatic test_timeout();
      int s = stb_n, d = done_n;
      ack_en = 1'b0;
      issue(1'b0, 32'h600, 8'd3, 3'd1);
      wait_done(d, "timeout");
      ack_en = 1'b1;
      total++;
      if (stb_n - s !== 10 || {status_err, status_timeout, status_beats} !== {1'b1, 1'b1, 9'd0}) begin
         bad++; $display("FAIL timeout: stbs=%0d err=%b tmo=%b beats=%0d want 10 1 1 0",
                         stb_n - s, status_err, status_timeout, status_beats);
      end
   endtask

   task automatic test_reset_mid_burst();
      int base = sl_cnt, d = done_n;
      ack_en = 1'b1;
      issue(1'b0, 32'h700, 8'd3, 3'd1);
      for (int i = 0; i < 20 && sl_cnt != base + 2; i++) tick();
      total++;
      if (sl_cnt !== base + 2 || wb_stb_o !== 1'b1) begin
         bad++; $display("FAIL rstmid_reach: acks=%0d stb=%b want 2 1", sl_cnt - base, wb_stb_o);
      end
      ack_en = 1'b0;
      wb_rst = 1'b1;
      tick();
      total++;
      if ({wb_cyc_o, wb_stb_o, cmd_ready} !== 3'b001) begin
         bad++; $display("FAIL rstmid_bus: cyc=%b stb=%b ready=%b want 0 0 1", wb_cyc_o, wb_stb_o, cmd_ready);
      end
      wb_rst = 1'b0;
      ack_en = 1'b1;
      repeat (5) tick();
      total++;
      if (done_n - d !== 0 || status_beats !== 9'd0 || cmd_ready !== 1'b1) begin
         bad++; $display("FAIL rstmid_nodone: done=%0d beats=%0d ready=%b want 0 0 1",
                         done_n - d, status_beats, cmd_ready);
      end
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_burst = '0;
      wdat_valid = 1'b0; wdat = '0; wsel = '0;
      wb_rst = 1'b1;
      test_reset();
      test_classic_write();
      test_classic_gap_read();
      test_wrap4_read();
      test_linear_stall_write();
      test_single_burst();
      test_err_read();
      test_rty();
      test_timeout();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter dw, default 32, meaning data width in bits (multiple of 8).
REQ-002 SHALL have parameter aw, default 32, meaning address width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning maximum cycles the block waits per beat for ack or err.
REQ-004 SHALL have port wb_clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_we in 1, cmd_adr in aw, cmd_len in 8 (beats minus one), cmd_burst in 3 (0 classic, 1 linear, 2 wrap4, 3 wrap8, 4 wrap16), forming the command handshake.
REQ-007 SHALL have ports wdat_valid in 1, wdat_ready out 1, wdat in dw, wsel in dw/8, the write-data handshake.
REQ-008 SHALL have ports rdat_valid out 1, rdat out dw, the read-data output, with no backpressure.
REQ-009 SHALL have ports done out 1 (one-cycle pulse), status_err out 1, status_timeout out 1, status_beats out 9.
REQ-010 SHALL have Wishbone master ports wb_adr_o aw, wb_dat_o dw, wb_sel_o dw/8, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o 3, wb_bte_o 2 (outputs) and wb_dat_i dw, wb_ack_i, wb_err_i, wb_rty_i (inputs).

Function
REQ-011 SHALL implement FSM states IDLE, BEAT, GAP, FINISH.
REQ-012 SHALL assert cmd_ready only in IDLE; cmd_valid&cmd_ready latches the command and moves to BEAT next cycle with wb_cyc_o=1.
REQ-013 SHALL drive wb_stb_o=1 in BEAT, except for writes while the one-entry write register is empty.
REQ-014 SHALL assert wdat_ready for writes when the write register is empty or is being consumed by an ack in the same cycle.
REQ-015 SHALL drive wb_cti_o=000 and wb_bte_o=00 on every beat for classic; after each ack enter GAP for exactly one cycle (cyc=1, stb=0), then BEAT.
REQ-016 SHALL, for bursts, drive wb_cti_o=010 on all beats except the last, which carries 111, keeping stb high across acks.
REQ-017 SHALL drive wb_bte_o 00/01/10/11 for linear/wrap4/wrap8/wrap16.
REQ-018 SHALL advance the address by dw/8 per ack; wrap bursts wrap modulo (N*dw/8) within the aligned N-beat block, upper bits unchanged; linear and classic add with natural aw-bit wrap-around.
REQ-019 SHALL register read data: rdat_valid=1 and rdat=wb_dat_i in the cycle after each read ack.
REQ-020 SHALL, on wb_err_i, set status_err, end the cycle (cyc=stb=0 next cycle) and enter FINISH; wb_err_i with wb_ack_i counts as err.
REQ-021 SHALL treat wb_rty_i as err.
REQ-022 SHALL count cycles in BEAT with stb high and no ack/err; reaching TIMEOUT sets status_err and status_timeout and aborts as REQ-020.
REQ-023 SHALL count accepted acks in status_beats (0 to 256).
REQ-024 SHALL, after the last ack, deassert cyc and stb next cycle, pulse done in FINISH, then return to IDLE.
REQ-025 SHALL clear status_* when a new command is accepted; they hold from done until then.
REQ-026 SHALL take cmd_len=0 on a burst type as a single beat with cti=111.

Reset
REQ-027 SHALL, with wb_rst high at an edge, enter IDLE; all outputs 0 except cmd_ready=1; write register empty; counters 0.
REQ-028 SHALL abort an in-flight cycle on reset (cyc/stb low the following cycle) with no done pulse.

Structure
REQ-029 SHALL take CTI/BTE codes and burst-type constants from the shared wb_common definitions, not local literals.
REQ-030 SHALL place next-address computation in sub-module wb_next_adr (inputs adr, burst type; output next adr), purely combinational.

Verification
REQ-031 Classic write, adr 0x100, len 0, wdat 0xDEADBEEF, sel 0xF -> one stb with cti 000, dat_o 0xDEADBEEF, done, status_beats 1.
REQ-032 Wrap4 read, adr 0x1C, len 3, slave acks each cycle -> addresses 0x1C,0x10,0x14,0x18; cti 010,010,010,111; bte 01; four rdat_valid pulses.
REQ-033 Linear write len 7 with wdat_valid low for 3 cycles before beat 3 -> stb low 3 cycles, cyc high, cti held, 8 beats total.
REQ-034 Read len 3, slave errs on beat 2 -> cyc low next cycle, status_err 1, status_beats 1, done pulse.
REQ-035 TIMEOUT=10, slave never acks -> abort after 10 stb cycles, status_timeout 1, status_err 1.
REQ-036 wb_rst high mid-burst beat 2 -> cyc/stb low next cycle, no done, cmd_ready 1.
